m_axi_lite_seq_master: RTL

- Parametrised AXI4-Lite master sequencer: issues C_NUM_TXN sequential single-beat transfers from a base address with a programmable stride.
- Generalises the fixed 4-word write/readback flow to three run modes: write-only, read-compare, write-then-readback-compare.
- Sits between a control/status register bank (start, mode, seed, results) and an AXI4-Lite interconnect slave port.
- Keeps one transaction outstanding at a time and reports error count plus first failing index.

---
 rtl/m_axi_lite_seq_pkg.sv | 26 ++
 rtl/m_axi_lite_seq_patgen.sv | 89 ++++++++
 rtl/m_axi_lite_seq_master.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/m_axi_lite_seq_pkg.sv
// Shared types and constants for the AXI4-Lite sequencing master.
//   mode_e  : run mode sampled on start
//   state_e : sequencer FSM state
package m_axi_lite_seq_pkg;

  typedef enum logic [1:0] {
    MODE_WR   = 2'b00,
    MODE_RD   = 2'b01,
    MODE_WRRD = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_FINISH
  } state_e;

  localparam int unsigned CNT_W        = 16;
  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [15:0] ERR_IDX_NONE = 16'hFFFF;

endpackage

// File: rtl/m_axi_lite_seq_patgen.sv
// Address/data pattern generator: tracks transfer index k and produces
// addr_k = base + k*stride and data_k = seed + k incrementally.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   load_i            : capture base/seed and restart at k=0
//   restart_i         : rewind to k=0 using the captured base/seed
//   incr_i            : advance to k+1
//   addr_o/data_o     : current address/data for index k
//   idx_o, last_o     : current index and "k is the final index" flag
module m_axi_lite_seq_patgen
  import m_axi_lite_seq_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH  = 32,
  parameter int unsigned C_DATA_WIDTH  = 32,
  parameter int unsigned C_NUM_TXN     = 4,
  parameter int unsigned C_ADDR_STRIDE = C_DATA_WIDTH / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic                    restart_i,
  input  logic                    incr_i,
  input  logic [C_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [C_DATA_WIDTH-1:0] seed_i,
  output logic [C_ADDR_WIDTH-1:0] addr_o,
  output logic [C_DATA_WIDTH-1:0] data_o,
  output logic [CNT_W-1:0]        idx_o,
  output logic                    last_o
);

  localparam logic [C_ADDR_WIDTH-1:0] STRIDE   = C_ADDR_WIDTH'(C_ADDR_STRIDE);
  localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(C_NUM_TXN - 1);

  logic [C_ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic [C_DATA_WIDTH-1:0] seed_q, seed_d, data_q, data_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic                    last_q, last_d;

  // Next pattern; last flag is precomputed so the FSM sees it as a register.
  always_comb begin
    base_d = base_q;
    seed_d = seed_q;
    addr_d = addr_q;
    data_d = data_q;
    idx_d  = idx_q;
    last_d = last_q;
    if (load_i) begin
      base_d = base_addr_i;
      seed_d = seed_i;
      addr_d = base_addr_i;
      data_d = seed_i;
      idx_d  = '0;
      last_d = (LAST_IDX == '0);
    end else if (restart_i) begin
      addr_d = base_q;
      data_d = seed_q;
      idx_d  = '0;
      last_d = (LAST_IDX == '0);
    end else if (incr_i) begin
      addr_d = addr_q + STRIDE;
      data_d = data_q + C_DATA_WIDTH'(1);
      idx_d  = idx_q + CNT_W'(1);
      last_d = ((idx_q + CNT_W'(1)) == LAST_IDX);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q <= '0;
      seed_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else begin
      base_q <= base_d;
      seed_q <= seed_d;
      addr_q <= addr_d;
      data_q <= data_d;
      idx_q  <= idx_d;
      last_q <= last_d;
    end
  end

  assign addr_o = addr_q;
  assign data_o = data_q;
  assign idx_o  = idx_q;
  assign last_o = last_q;

endmodule

// File: rtl/m_axi_lite_seq_master.sv
// AXI4-Lite sequencing master: runs C_NUM_TXN single-beat transfers
// (write-only, read-compare, or write-then-readback-compare) with one
// transaction outstanding, and reports error count / first failing index.
//   ACLK, ARESET              : clock, synchronous active-high reset
//   start, mode, base_addr, seed : run request and its parameters
//   busy, done, error, err_count, first_err_idx : run status
//   M_AXI_*                   : AXI4-Lite master port (AW, W, B, AR, R)
module m_axi_lite_seq_master
  import m_axi_lite_seq_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH  = 32,
  parameter int unsigned C_DATA_WIDTH  = 32,
  parameter int unsigned C_NUM_TXN     = 4,
  parameter int unsigned C_ADDR_STRIDE = C_DATA_WIDTH / 8
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [C_ADDR_WIDTH-1:0]   base_addr,
  input  logic [C_DATA_WIDTH-1:0]   seed,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [15:0]               err_count,
  output logic [15:0]               first_err_idx,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [CNT_W-1:0] err_count_q, err_count_d, first_q, first_d;
  logic             awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic             arvalid_q, arvalid_d, rready_q, rready_d;

  logic                    pg_load, pg_restart, pg_incr, pg_last, hit_err;
  logic [C_ADDR_WIDTH-1:0] pg_addr;
  logic [C_DATA_WIDTH-1:0] pg_data;
  logic [CNT_W-1:0]        pg_idx;

  m_axi_lite_seq_patgen #(
    .C_ADDR_WIDTH (C_ADDR_WIDTH),
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .C_NUM_TXN    (C_NUM_TXN),
    .C_ADDR_STRIDE(C_ADDR_STRIDE)
  ) u_patgen (
    .clk_i      (ACLK),
    .rst_i      (ARESET),
    .load_i     (pg_load),
    .restart_i  (pg_restart),
    .incr_i     (pg_incr),
    .base_addr_i(base_addr),
    .seed_i     (seed),
    .addr_o     (pg_addr),
    .data_o     (pg_data),
    .idx_o      (pg_idx),
    .last_o     (pg_last)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    err_count_d = err_count_q;
    first_d     = first_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    pg_load     = 1'b0;
    pg_restart  = 1'b0;
    pg_incr     = 1'b0;
    hit_err     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d      = mode_e'(mode);
          pg_load     = 1'b1;
          error_d     = 1'b0;
          err_count_d = '0;
          first_d     = ERR_IDX_NONE;
          case (mode_e'(mode))
            MODE_WR, MODE_WRRD: begin
              state_d   = ST_WR_REQ;
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              busy_d    = 1'b1;
            end
            MODE_RD: begin
              state_d   = ST_RD_REQ;
              arvalid_d = 1'b1;
              busy_d    = 1'b1;
            end
            default: begin
              // Reserved mode: flag and finish without touching the bus.
              state_d = ST_FINISH;
              done_d  = 1'b1;
              error_d = 1'b1;
            end
          endcase
        end
      end

      ST_WR_REQ: begin
        // AW and W retire independently; advance once both are gone.
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = ST_WR_RESP;
          bready_d = 1'b1;
        end
      end

      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          hit_err  = (M_AXI_BRESP != RESP_OKAY);
          if (!pg_last) begin
            pg_incr   = 1'b1;
            state_d   = ST_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else if (mode_q == MODE_WRRD) begin
            pg_restart = 1'b1;
            state_d    = ST_RD_REQ;
            arvalid_d  = 1'b1;
          end else begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end

      ST_RD_REQ: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_RESP;
        end
      end

      ST_RD_RESP: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          hit_err  = (M_AXI_RRESP != RESP_OKAY) || (M_AXI_RDATA != pg_data);
          if (!pg_last) begin
            pg_incr   = 1'b1;
            state_d   = ST_RD_REQ;
            arvalid_d = 1'b1;
          end else begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Saturating error count; index is captured on the run's first error.
    if (hit_err) begin
      error_d = 1'b1;
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + CNT_W'(1);
      if (!error_q) first_d = pg_idx;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_WR;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
      first_q     <= ERR_IDX_NONE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
      first_q     <= first_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_q;

  assign M_AXI_AWADDR  = pg_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = pg_data;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = pg_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
